// File: rtl/cmp_minmax.sv
// ============================================================================
// Module   : cmp_minmax (with helper cmp)
// Brief    : Streaming per-frame min/max reduction with first-occurrence indices
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp #(
  parameter int ORDER = 3
) (
  input  logic [2**ORDER-1:0] a,
  input  logic [2**ORDER-1:0] b,
  output logic                gt
);
  assign gt = (a > b);
endmodule

module cmp_minmax #(
  parameter int ORDER = 3,
  parameter int IW    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [2**ORDER-1:0] s_data,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [2**ORDER-1:0] m_min,
  output logic [2**ORDER-1:0] m_max,
  output logic [IW-1:0]       m_min_idx,
  output logic [IW-1:0]       m_max_idx,
  output logic [IW:0]         m_count,
  output logic                m_ovf
);

  localparam int W = 2**ORDER;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_acc  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]    r_state;
  logic [W-1:0]  r_cur_min;
  logic [W-1:0]  r_cur_max;
  logic [IW-1:0] r_min_idx;
  logic [IW-1:0] r_max_idx;
  logic [IW:0]   r_cnt;
  logic          r_ovf;

  logic          w_in_fire;
  logic          w_sat;
  logic [IW-1:0] w_idx;
  logic          w_new_min;
  logic          w_new_max;
  logic [W-1:0]  w_nxt_min;
  logic [W-1:0]  w_nxt_max;
  logic [IW-1:0] w_nxt_min_idx;
  logic [IW-1:0] w_nxt_max_idx;
  logic [IW:0]   w_nxt_cnt;
  logic          w_nxt_ovf;

  assign s_ready   = (r_state != c_done);
  assign w_in_fire = s_valid & s_ready;

  // Count reaching 2**IW means the current beat lies beyond the index space.
  assign w_sat = r_cnt[IW];
  assign w_idx = w_sat ? {IW{1'b1}} : r_cnt[IW-1:0];

  cmp #(.ORDER(ORDER)) u_cmp_min (
    .a  (r_cur_min),
    .b  (s_data),
    .gt (w_new_min)
  );

  cmp #(.ORDER(ORDER)) u_cmp_max (
    .a  (s_data),
    .b  (r_cur_max),
    .gt (w_new_max)
  );

  always_comb begin
    w_nxt_min     = r_cur_min;
    w_nxt_max     = r_cur_max;
    w_nxt_min_idx = r_min_idx;
    w_nxt_max_idx = r_max_idx;
    w_nxt_cnt     = r_cnt;
    w_nxt_ovf     = r_ovf;
    if (r_state == c_idle) begin
      w_nxt_min     = s_data;
      w_nxt_max     = s_data;
      w_nxt_min_idx = '0;
      w_nxt_max_idx = '0;
      w_nxt_cnt     = {{IW{1'b0}}, 1'b1};
      w_nxt_ovf     = 1'b0;
    end else begin
      // Strict compares keep the earliest index on ties.
      if (w_new_min) begin
        w_nxt_min     = s_data;
        w_nxt_min_idx = w_idx;
      end
      if (w_new_max) begin
        w_nxt_max     = s_data;
        w_nxt_max_idx = w_idx;
      end
      w_nxt_cnt = w_sat ? r_cnt : (r_cnt + {{IW{1'b0}}, 1'b1});
      w_nxt_ovf = r_ovf | w_sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_idle;
      r_cur_min <= '0;
      r_cur_max <= '0;
      r_min_idx <= '0;
      r_max_idx <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      m_valid   <= 1'b0;
      m_min     <= '0;
      m_max     <= '0;
      m_min_idx <= '0;
      m_max_idx <= '0;
      m_count   <= '0;
      m_ovf     <= 1'b0;
    end else begin
      case (r_state)
        c_idle, c_acc: begin
          if (w_in_fire) begin
            r_cur_min <= w_nxt_min;
            r_cur_max <= w_nxt_max;
            r_min_idx <= w_nxt_min_idx;
            r_max_idx <= w_nxt_max_idx;
            r_cnt     <= w_nxt_cnt;
            r_ovf     <= w_nxt_ovf;
            if (s_last) begin
              m_min     <= w_nxt_min;
              m_max     <= w_nxt_max;
              m_min_idx <= w_nxt_min_idx;
              m_max_idx <= w_nxt_max_idx;
              m_count   <= w_nxt_cnt;
              m_ovf     <= w_nxt_ovf;
              m_valid   <= 1'b1;
              r_state   <= c_done;
            end else begin
              r_state   <= c_acc;
            end
          end
        end
        c_done: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cmp_minmax.sv
// ============================================================================
// Module   : tb_cmp_minmax
// Brief    : Scoreboard bench for cmp_minmax at IW=8 and IW=2 on shared stimulus
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmp_minmax;

  typedef struct {
    int mn;
    int mx;
    int mn_i;
    int mx_i;
    int cnt;
    int ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_last = 1'b0;
  logic       m_ready = 1'b1;

  logic       s_ready8, m_valid8, m_ovf8;
  logic [7:0] m_min8, m_max8, m_min_idx8, m_max_idx8;
  logic [8:0] m_count8;

  logic       s_ready2, m_valid2, m_ovf2;
  logic [7:0] m_min2, m_max2;
  logic [1:0] m_min_idx2, m_max_idx2;
  logic [2:0] m_count2;

  int tests = 0;
  int fails = 0;
  exp_t exp8_q[$];
  exp_t exp2_q[$];

  always #5 clk = ~clk;

  cmp_minmax #(.ORDER(3), .IW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready8),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid8), .m_ready(m_ready),
    .m_min(m_min8), .m_max(m_max8), .m_min_idx(m_min_idx8),
    .m_max_idx(m_max_idx8), .m_count(m_count8), .m_ovf(m_ovf8)
  );

  cmp_minmax #(.ORDER(3), .IW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready2),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid2), .m_ready(m_ready),
    .m_min(m_min2), .m_max(m_max2), .m_min_idx(m_min_idx2),
    .m_max_idx(m_max_idx2), .m_count(m_count2), .m_ovf(m_ovf2)
  );

  // Reference reduction for a whole frame at a given index width.
  function automatic exp_t model(input int q[$], input int iw);
    exp_t e;
    int cap;
    int idx;
    cap    = 1 << iw;
    e.mn   = q[0];
    e.mx   = q[0];
    e.mn_i = 0;
    e.mx_i = 0;
    for (int i = 1; i < q.size(); i++) begin
      idx = (i >= cap) ? cap - 1 : i;
      if (q[i] < e.mn) begin e.mn = q[i]; e.mn_i = idx; end
      if (q[i] > e.mx) begin e.mx = q[i]; e.mx_i = idx; end
    end
    e.cnt = (q.size() > cap) ? cap : q.size();
    e.ovf = (q.size() > cap) ? 1 : 0;
    return e;
  endfunction

  // Output monitor: pops the scoreboard on every accepted result beat.
  always @(negedge clk) begin
    exp_t e;
    if (m_valid8 && m_ready) begin
      tests++;
      if (exp8_q.size() == 0) begin
        fails++;
        $display("FAIL res8_unexpected: got min=%0d max=%0d, required no result", m_min8, m_max8);
      end else begin
        e = exp8_q.pop_front();
        if (int'(m_min8) !== e.mn || int'(m_max8) !== e.mx || int'(m_min_idx8) !== e.mn_i ||
            int'(m_max_idx8) !== e.mx_i || int'(m_count8) !== e.cnt || int'(m_ovf8) !== e.ovf) begin
          fails++;
          $display("FAIL res8: got min=%0d/%0d max=%0d/%0d cnt=%0d ovf=%0d, required min=%0d/%0d max=%0d/%0d cnt=%0d ovf=%0d",
                   m_min8, m_min_idx8, m_max8, m_max_idx8, m_count8, m_ovf8,
                   e.mn, e.mn_i, e.mx, e.mx_i, e.cnt, e.ovf);
        end
      end
    end
    if (m_valid2 && m_ready) begin
      tests++;
      if (exp2_q.size() == 0) begin
        fails++;
        $display("FAIL res2_unexpected: got min=%0d max=%0d, required no result", m_min2, m_max2);
      end else begin
        e = exp2_q.pop_front();
        if (int'(m_min2) !== e.mn || int'(m_max2) !== e.mx || int'(m_min_idx2) !== e.mn_i ||
            int'(m_max_idx2) !== e.mx_i || int'(m_count2) !== e.cnt || int'(m_ovf2) !== e.ovf) begin
          fails++;
          $display("FAIL res2: got min=%0d/%0d max=%0d/%0d cnt=%0d ovf=%0d, required min=%0d/%0d max=%0d/%0d cnt=%0d ovf=%0d",
                   m_min2, m_min_idx2, m_max2, m_max_idx2, m_count2, m_ovf2,
                   e.mn, e.mn_i, e.mx, e.mx_i, e.cnt, e.ovf);
        end
      end
    end
  end

  // Entered and left just after a rising edge.
  task automatic send_beat(input int d, input bit last, input int gap);
    int n;
    s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = d[7:0];
    s_last  = last;
    n = 0;
    @(negedge clk);
    while (!s_ready8 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got s_ready=0 for 50 cycles, required 1");
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int q[$], input int maxgap);
    exp8_q.push_back(model(q, 8));
    exp2_q.push_back(model(q, 2));
    for (int i = 0; i < q.size(); i++)
      send_beat(q[i], i == q.size() - 1, (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (m_valid8 !== 1'b0 || s_ready8 !== 1'b1 || m_min8 !== 8'd0 || m_max8 !== 8'd0 ||
        m_count8 !== 9'd0 || m_ovf8 !== 1'b0 || m_min_idx8 !== 8'd0 || m_max_idx8 !== 8'd0) begin
      fails++;
      $display("FAIL reset8: got valid=%b ready=%b min=%0d max=%0d cnt=%0d ovf=%b, required 0 1 0 0 0 0",
               m_valid8, s_ready8, m_min8, m_max8, m_count8, m_ovf8);
    end
    tests++;
    if (m_valid2 !== 1'b0 || s_ready2 !== 1'b1 || m_count2 !== 3'd0 || m_ovf2 !== 1'b0) begin
      fails++;
      $display("FAIL reset2: got valid=%b ready=%b cnt=%0d ovf=%b, required 0 1 0 0",
               m_valid2, s_ready2, m_count2, m_ovf2);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    m_ready = 1'b1;
    send_frame('{5, 2, 9, 2, 9}, 0);
    @(negedge clk);
    tests++;
    if (m_valid8 !== 1'b1 || s_ready8 !== 1'b0) begin
      fails++;
      $display("FAIL basic_valid: got valid=%b ready=%b, required 1 0", m_valid8, s_ready8);
    end
    @(negedge clk);
    tests++;
    if (m_valid8 !== 1'b0 || s_ready8 !== 1'b1) begin
      fails++;
      $display("FAIL basic_one_cycle: got valid=%b ready=%b, required 0 1", m_valid8, s_ready8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    send_frame('{8'hA5}, 0);
    @(negedge clk);
    tests++;
    if (m_valid8 !== 1'b1 || m_min8 !== 8'hA5 || m_max8 !== 8'hA5) begin
      fails++;
      $display("FAIL single: got valid=%b min=%0h max=%0h, required 1 a5 a5", m_valid8, m_min8, m_max8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b0;
    send_frame('{3, 7}, 0);
    s_valid = 1'b1;
    s_data  = 8'd1;
    s_last  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (m_valid8 !== 1'b1 || m_min8 !== 8'd3 || m_max8 !== 8'd7 || m_count8 !== 9'd2 ||
          m_min_idx8 !== 8'd0 || m_max_idx8 !== 8'd1 || s_ready8 !== 1'b0) begin
        fails++;
        $display("FAIL hold_%0d: got valid=%b min=%0d max=%0d cnt=%0d ready=%b, required 1 3 7 2 0",
                 k, m_valid8, m_min8, m_max8, m_count8, s_ready8);
      end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    send_frame('{1, 1}, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_gaps();
    send_frame('{255, 255, 255, 255, 255}, 3);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_overflow();
    send_frame('{4, 3, 2, 1, 0, 8}, 0);
    @(negedge clk);
    tests++;
    if (m_ovf2 !== 1'b1 || m_count2 !== 3'd4 || m_ovf8 !== 1'b0) begin
      fails++;
      $display("FAIL ovf_flag: got ovf2=%b cnt2=%0d ovf8=%b, required 1 4 0", m_ovf2, m_count2, m_ovf8);
    end
    @(posedge clk); #1;
    send_frame('{7, 5}, 0);
    @(negedge clk);
    tests++;
    if (m_ovf2 !== 1'b0 || m_count2 !== 3'd2) begin
      fails++;
      $display("FAIL ovf_clear: got ovf2=%b cnt2=%0d, required 0 2", m_ovf2, m_count2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    send_beat(9, 1'b0, 0);
    send_beat(1, 1'b0, 0);
    send_beat(5, 1'b0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (m_valid8 !== 1'b0 || s_ready8 !== 1'b1 || m_min8 !== 8'd0 || m_max8 !== 8'd0 ||
        m_count8 !== 9'd0 || m_min_idx8 !== 8'd0 || m_max_idx8 !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid: got valid=%b ready=%b min=%0d max=%0d cnt=%0d, required 0 1 0 0 0",
               m_valid8, s_ready8, m_min8, m_max8, m_count8);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame('{6, 4}, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_back_to_back();
    test_gaps();
    test_overflow();
    test_reset_mid();
    repeat (5) @(negedge clk);
    tests++;
    if (exp8_q.size() != 0 || exp2_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending results, required 0/0", exp8_q.size(), exp2_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
